m_queue_pop_front: RTL

- Hardware counterpart to the push-side queue logic: a bounded, clocked queue of signed 32-bit elements.
- Elements are loaded through a push handshake and drained from the front through a valid/ready pop port.
- Live size, wrap-around sum and minimum statistics are kept over the occupied entries.
- Sits between a producer that builds the queue and a consumer that drains it.

---
 rtl/m_queue_pkg.sv | 14 +
 rtl/m_queue_min_scan.sv | 27 ++
 rtl/m_queue_pop_front.sv | 112 +++++++++++
 3 files changed

// File: rtl/m_queue_pkg.sv
// Shared element/size types and helpers for the bounded signed-element queue.
package m_queue_pkg;

  localparam int DATA_W      = 32;
  localparam int QUEUE_DEPTH = 8;

  typedef logic signed [DATA_W-1:0]            data_t;
  typedef logic [$clog2(QUEUE_DEPTH+1)-1:0]    size_t;

  function automatic data_t smin(input data_t a, input data_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/m_queue_min_scan.sv
// Combinational signed minimum over the occupied prefix of an entry array.
// Returns 0 when no entry is occupied.
module m_queue_min_scan
  import m_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  data_t            i_entries [DEPTH],
  input  logic [CNT_W-1:0] i_count,
  output data_t            o_min
);

  data_t w_acc;

  always_comb begin
    w_acc = '0;
    if (i_count != '0) begin
      w_acc = i_entries[0];
      for (int i = 1; i < DEPTH; i++) begin
        if (i < int'(i_count)) w_acc = smin(w_acc, i_entries[i]);
      end
    end
    o_min = w_acc;
  end

endmodule

// File: rtl/m_queue_pop_front.sv
// Bounded signed-element queue with push handshake, valid/ready front pop and
// live size/sum/min statistics. Define QUEUE_SORTED_POP_EN for ascending ordered insertion.
module m_queue_pop_front
  import m_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push_valid,
  input  logic [DATA_W-1:0]          i_push_data,
  output logic                       o_push_ready,
  output logic                       o_pop_valid,
  output logic [DATA_W-1:0]          o_pop_data,
  input  logic                       i_pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_size_out,
  output logic [DATA_W-1:0]          o_sum_out,
  output logic [DATA_W-1:0]          o_min_out
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] r_count;
  data_t            r_entries [DEPTH];
  data_t            r_sum;

  data_t            w_base [DEPTH];
  data_t            w_next [DEPTH];
  data_t            w_push_data;
  data_t            w_min;
  logic             w_push;
  logic             w_pop;
  int               w_base_cnt;

  assign w_push_data  = i_push_data;
  assign o_pop_valid  = (r_count != '0);
  assign o_pop_data   = r_entries[0];
  // A full queue still accepts when the front leaves on the same edge.
  assign o_push_ready = (r_count < CNT_W'(DEPTH)) || (o_pop_valid && i_pop_ready);
  assign w_pop        = o_pop_valid && i_pop_ready;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_base_cnt   = int'(r_count) - (w_pop ? 1 : 0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_base[i] = r_entries[i];
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) w_base[i] = r_entries[i + 1];
      w_base[DEPTH - 1] = '0;
    end
  end

`ifdef QUEUE_SORTED_POP_EN
  int w_ins_idx;

  // Insert after every equal-or-smaller element so equal values keep arrival order.
  always_comb begin
    w_ins_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < w_base_cnt && w_base[i] <= w_push_data) w_ins_idx = i + 1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_push || i < w_ins_idx) w_next[i] = w_base[i];
      else if (i == w_ins_idx)      w_next[i] = w_push_data;
      else                          w_next[i] = w_base[(i > 0) ? i - 1 : 0];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_next[i] = w_base[i];
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == w_base_cnt) w_next[i] = w_push_data;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_sum   <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
      r_sum   <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
    end else begin
      r_entries <= w_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_sum <= r_sum + (w_push ? w_push_data : '0) - (w_pop ? r_entries[0] : '0);
    end
  end

  m_queue_min_scan #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_min_scan (
    .i_entries (r_entries),
    .i_count   (r_count),
    .o_min     (w_min)
  );

  assign o_size_out = r_count;
  assign o_sum_out  = r_sum;
  assign o_min_out  = w_min;

endmodule
